sample_accum_seq: RTL and testbench
===================================

Name: sample_accum_seq

Overview:
- Sequencer sitting directly upstream of the team's combinational 8-bit full_adder (ports a, b, cin -> s, cout).
- Accepts a stream of 8-bit sensor samples over a valid/ready handshake.
- Accumulates N_SAMPLES of them into a 16-bit total by time-multiplexing the single external 8-bit adder: low byte, then high byte with carry.
- Presents the finished total, with a sticky overflow flag, on an output valid/ready handshake.

Parameters:
- N_SAMPLES, 4, samples per accumulation. Legal range 1..1024. Counter width is clog2(N_SAMPLES+1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous abort. Discards the partial accumulation and returns to IDLE.
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a sample
- in_data  input  8  unsigned sample
- add_a  output  8  operand A to external adder
- add_b  output  8  operand B to external adder
- add_cin  output  1  carry-in to external adder
- add_s  input  8  sum returned by external adder (combinational, same cycle)
- add_cout  input  1  carry-out returned by external adder
- out_valid  output  1  out_sum/out_ovf are valid
- out_ready  input  1  consumer accepts the result
- out_sum  output  16  accumulated total, mod 2^16
- out_ovf  output  1  sticky: total exceeded 16'hFFFF

Behaviour:
- Reset (rst=1 at clock edge):
  - State=IDLE.
  - acc=0, count=0, carry_reg=0, ovf=0, sample_reg=0.
  - Outputs: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, add_a=0, add_b=0, add_cin=0.
- Priority: rst > clear > normal operation. clear has the same effect as rst on state and registers.
- FSM states: IDLE, ADD_LO, ADD_HI, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: sample_reg<=in_data, go to ADD_LO.
  - Otherwise stay in IDLE.
- ADD_LO (1 cycle):
  - Drives add_a=acc[7:0], add_b=sample_reg, add_cin=0. in_ready=0.
  - At the edge: acc[7:0]<=add_s, carry_reg<=add_cout, go to ADD_HI.
- ADD_HI (1 cycle):
  - Drives add_a=acc[15:8], add_b=8'h00, add_cin=carry_reg. in_ready=0.
  - At the edge: acc[15:8]<=add_s, ovf<=ovf|add_cout.
  - If count==N_SAMPLES-1: count<=0, go to DONE.
  - Else: count<=count+1, go to IDLE.
- DONE:
  - out_valid=1, out_sum=acc, out_ovf=ovf, in_ready=0.
  - On out_ready=1: acc<=0, ovf<=0, carry_reg<=0, go to IDLE. out_valid drops the next cycle.
  - While out_ready=0: out_sum and out_ovf are held stable and no samples are accepted.
- Adder drive outside ADD_LO/ADD_HI: add_a, add_b and add_cin are all 0.
- out_sum and out_ovf read 0 whenever out_valid=0.
- Timing:
  - Throughput: 3 cycles per sample (IDLE accept, ADD_LO, ADD_HI).
  - Latency: final sample accept to out_valid=1 is 3 cycles.
  - Minimum cycles per accumulation: 3*N_SAMPLES+1.
- Arithmetic: unsigned. Wrap-around mod 2^16. ovf is set on any high-byte carry-out and is never cleared except by DONE handshake, clear or rst.
- in_valid while in_ready=0: ignored. The upstream source must hold the sample.
- clear or rst during ADD_LO or ADD_HI: the in-flight sample is dropped and no partial result is emitted.
- N_SAMPLES=1: every accepted sample goes directly to DONE after ADD_HI.

Test Plan:
- Basic, N_SAMPLES=4, samples 55, 15, 255, 1, no backpressure -> out_valid after 13th cycle from first accept; out_sum=16'h0146 (326); out_ovf=0.
- Low-byte carry, N_SAMPLES=2, samples 8'hFF, 8'h01 -> ADD_HI of second sample drives add_cin=1; out_sum=16'h0100; out_ovf=0.
- Overflow, N_SAMPLES=258, all samples 8'hFF -> out_sum=16'h00FE; out_ovf=1. Next accumulation of 258 zeros -> out_sum=0; out_ovf=0.
- Backpressure: in DONE with out_ready=0 for 5 cycles, in_valid=1 -> out_valid=1 and out_sum stable all 5 cycles, in_ready=0, no sample consumed. out_ready=1 -> IDLE next cycle; held sample accepted on the following cycle.
- Reset/clear mid-operation: after 2 samples (N_SAMPLES=4), assert rst during ADD_HI -> next cycle all outputs at reset values. Then 4 samples of 8'h10 -> out_sum=16'h0040. Repeat using clear during ADD_LO -> same result.
- Adder idle drive: in IDLE and DONE -> add_a=0, add_b=0, add_cin=0 every cycle.

Source files
------------

// File: rtl/sample_accum_seq.sv
// Accumulates N_SAMPLES unsigned 8-bit samples into a 16-bit total by driving one
// external 8-bit adder twice per sample (low byte, then high byte with carry).
module sample_accum_seq #(
    parameter int N_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_cin,
    input  logic [7:0]  add_s,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_ovf
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD_LO,
        ADD_HI,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        acc;
    logic [CNT_W-1:0]   count;
    logic               carry_reg;
    logic               ovf;
    logic [7:0]         sample_reg;
    logic               last_sample;

    assign last_sample = (count == CNT_W'(N_SAMPLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        add_a     = 8'h00;
        add_b     = 8'h00;
        add_cin   = 1'b0;
        out_valid = 1'b0;
        out_sum   = 16'h0000;
        out_ovf   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ADD_LO;
                end
            end
            ADD_LO: begin
                add_a     = acc[7:0];
                add_b     = sample_reg;
                state_nxt = ADD_HI;
            end
            ADD_HI: begin
                // High byte only absorbs the carry from the low-byte add.
                add_a     = acc[15:8];
                add_cin   = carry_reg;
                state_nxt = last_sample ? DONE : IDLE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = acc;
                out_ovf   = ovf;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc        <= 16'h0000;
            count      <= '0;
            carry_reg  <= 1'b0;
            ovf        <= 1'b0;
            sample_reg <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sample_reg <= in_data;
                    end
                end
                ADD_LO: begin
                    acc[7:0]  <= add_s;
                    carry_reg <= add_cout;
                end
                ADD_HI: begin
                    acc[15:8] <= add_s;
                    ovf       <= ovf | add_cout;
                    count     <= last_sample ? '0 : count + CNT_W'(1);
                end
                DONE: begin
                    if (out_ready) begin
                        acc       <= 16'h0000;
                        ovf       <= 1'b0;
                        carry_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_accum_seq.sv
// Directed bench for sample_accum_seq: a 4-sample instance for the main flows and a
// 258-sample instance for 16-bit overflow; expected totals flow through a scoreboard queue.
module tb_sample_accum_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic [7:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_ovf;

    logic        in_valid_b = 1'b0;
    logic        in_ready_b;
    logic [7:0]  in_data_b = 8'h00;
    logic [7:0]  add_a_b, add_b_b, add_s_b;
    logic        add_cin_b, add_cout_b;
    logic        out_valid_b;
    logic        out_ready_b = 1'b0;
    logic [15:0] out_sum_b;
    logic        out_ovf_b;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] sb[$];
    int          model_acc = 0;
    int          model_cnt = 0;

    always #5 clk = ~clk;

    // Behavioural stand-ins for the external combinational full adder.
    assign {add_cout, add_s}     = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
    assign {add_cout_b, add_s_b} = {1'b0, add_a_b} + {1'b0, add_b_b} + {8'h00, add_cin_b};

    sample_accum_seq #(.N_SAMPLES(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    sample_accum_seq #(.N_SAMPLES(258)) dut_big (
        .clk(clk), .rst(rst), .clear(1'b0),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .add_a(add_a_b), .add_b(add_b_b), .add_cin(add_cin_b),
        .add_s(add_s_b), .add_cout(add_cout_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_sum(out_sum_b), .out_ovf(out_ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_sum"}, {16'd0, out_sum}, 32'd0);
        chk({tag, "_out_ovf"}, {31'd0, out_ovf}, 32'd0);
        chk({tag, "_adder"}, {15'd0, add_a, add_b, add_cin}, 32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge (DUT in ADD_LO).
    task automatic send(input logic [7:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [7:0] d);
        send(d);
        model_acc += int'(d);
        model_cnt++;
        if (model_cnt == 4) begin
            sb.push_back({model_acc > 32'hFFFF, model_acc[15:0]});
            model_acc = 0;
            model_cnt = 0;
        end
    endtask

    task automatic collect(input string tag);
        int t = 0;
        logic [16:0] exp;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
        exp = (sb.size() != 0) ? sb.pop_front() : 17'h1FFFF;
        chk({tag, "_sum"}, {16'd0, out_sum}, {16'd0, exp[15:0]});
        chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, exp[16]});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic reset_model();
        model_acc = 0;
        model_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held_sum;
        logic [16:0] exp_b;
        int t;
        int big_acc;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("reset");
        chk("reset_big_in_ready", {31'd0, in_ready_b}, 32'd1);
        chk("reset_big_out_valid", {31'd0, out_valid_b}, 32'd0);

        // Basic accumulation with latency check on the final sample.
        send_m(8'd55);
        send_m(8'd15);
        send_m(8'd255);
        send_m(8'd1);
        chk("lat_addlo_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_addhi_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_done_valid", {31'd0, out_valid}, 32'd1);
        chk("done_adder_idle", {15'd0, add_a, add_b, add_cin}, 32'd0);
        collect("basic");

        // Low-byte carry into the high byte.
        send_m(8'hFF);
        send_m(8'h01);
        chk("carry_lo_a", {24'd0, add_a}, 32'hFF);
        chk("carry_lo_b", {24'd0, add_b}, 32'h01);
        chk("carry_lo_cin", {31'd0, add_cin}, 32'd0);
        @(negedge clk);
        chk("carry_hi_cin", {31'd0, add_cin}, 32'd1);
        chk("carry_hi_ab", {16'd0, add_a, add_b}, 32'd0);
        send_m(8'h00);
        send_m(8'h00);
        collect("carry");

        // Backpressure in DONE with a sample waiting upstream.
        send_m(8'd3);
        send_m(8'd4);
        send_m(8'd5);
        send_m(8'd6);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        held_sum = (sb.size() != 0) ? sb[0][15:0] : 16'hDEAD;
        in_valid = 1'b1;
        in_data  = 8'h22;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sum", {16'd0, out_sum}, {16'd0, held_sum});
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_adder_idle", {15'd0, add_a, add_b, add_cin}, 32'd0);
            @(negedge clk);
        end
        void'(sb.pop_front());
        chk("bp_sum_final", {16'd0, out_sum}, 32'd18);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_idle_adder", {15'd0, add_a, add_b, add_cin}, 32'd0);
        @(negedge clk);
        chk("bp_held_accepted", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        model_acc = 32'h22;
        model_cnt = 1;
        send_m(8'd1);
        send_m(8'd1);
        send_m(8'd1);
        collect("bp_next");

        // rst during ADD_HI of the third sample.
        send(8'd1);
        send(8'd2);
        send(8'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst_mid");
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 4; i++) send_m(8'h10);
        collect("after_rst");

        // clear during ADD_LO of the third sample.
        send(8'd7);
        send(8'd8);
        send(8'd9);
        clear = 1'b1;
        @(negedge clk);
        chk_idle_outputs("clear_mid");
        clear = 1'b0;
        reset_model();
        for (int i = 0; i < 4; i++) send_m(8'h10);
        collect("after_clear");

        // 258 x 0xFF overflows 16 bits, then 258 zeros clears the result.
        big_acc = 0;
        for (int i = 0; i < 258; i++) big_acc += 255;
        sb.push_back({big_acc > 32'hFFFF, big_acc[15:0]});
        sb.push_back(17'h0);
        in_data_b  = 8'hFF;
        in_valid_b = 1'b1;
        for (int r = 0; r < 2; r++) begin
            t = 0;
            while (!out_valid_b && t < 1000) begin
                @(negedge clk);
                t++;
            end
            chk("big_valid", {31'd0, out_valid_b}, 32'd1);
            chk("big_in_ready", {31'd0, in_ready_b}, 32'd0);
            in_data_b = 8'h00;
            if (r == 1) in_valid_b = 1'b0;
            exp_b = (sb.size() != 0) ? sb.pop_front() : 17'h1FFFF;
            chk("big_sum", {16'd0, out_sum_b}, {16'd0, exp_b[15:0]});
            chk("big_ovf", {31'd0, out_ovf_b}, {31'd0, exp_b[16]});
            out_ready_b = 1'b1;
            @(negedge clk);
            out_ready_b = 1'b0;
            chk("big_valid_drop", {31'd0, out_valid_b}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
